// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: programmable clock divider with a glitch-free ratio handshake.
//
// div_out is a registered 50% duty clock whose half-period is active_ratio clk cycles.
// New ratios are requested through a valid/ready handshake. A request made while the
// divider is running is held in a pending register. It takes effect only at the next
// falling toggle of div_out, so that whole phases are always produced.
//
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   cfg_valid    in   configuration request strobe
//   cfg_ratio    in   requested half-period in clk cycles (0 = stop)
//   cfg_ready    out  request can be accepted this cycle
//   cfg_err      out  one-cycle pulse: ratio 0 requested while idle
//   div_out      out  divided clock (registered)
//   rise_pulse   out  one-cycle pulse on the first cycle div_out reads 1
//   busy         out  state is not IDLE
//   active_ratio out  half-period currently driving div_out
module div_ratio_ctrl #(
  parameter int unsigned HALF_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_valid,
  input  logic [HALF_W-1:0] cfg_ratio,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              div_out,
  output logic              rise_pulse,
  output logic              busy,
  output logic [HALF_W-1:0] active_ratio
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [HALF_W-1:0] One  = HALF_W'(1);
  localparam logic [HALF_W-1:0] Zero = '0;

  state_e            state_q, state_d;
  logic              div_q, div_d;
  logic              rise_q, rise_d;
  logic              err_q, err_d;
  logic [HALF_W-1:0] act_q, act_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic [HALF_W-1:0] pend_q, pend_d;
  logic              accept;

  // Ready and busy decode straight from state so reset forces them without a clock.
  assign cfg_ready    = (state_q != StDrain);
  assign busy         = (state_q != StIdle);
  assign accept       = cfg_valid & cfg_ready;
  assign cfg_err      = err_q;
  assign div_out      = div_q;
  assign rise_pulse   = rise_q;
  assign active_ratio = act_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        div_d = 1'b0;
        if (accept) begin
          if (cfg_ratio == Zero) begin
            err_d = 1'b1;
          end else begin
            div_d   = 1'b1;
            act_d   = cfg_ratio;
            cnt_d   = cfg_ratio - One;
            state_d = StRun;
          end
        end
      end

      StRun, StDrain: begin
        // act_q is never 0 here, so the reload cannot underflow.
        if (cnt_q == Zero) begin
          div_d = ~div_q;
          cnt_d = act_q - One;
        end else begin
          cnt_d = cnt_q - One;
        end

        if (state_q == StRun && accept) begin
          pend_d  = cfg_ratio;
          state_d = StDrain;
        end

        // Switch on the first 1->0 toggle after acceptance; the new low phase uses
        // the pending ratio, so no phase is ever truncated.
        if (state_q == StDrain && cnt_q == Zero && div_q) begin
          div_d = 1'b0;
          if (pend_q != Zero) begin
            act_d   = pend_q;
            cnt_d   = pend_q - One;
            state_d = StRun;
          end else begin
            act_d   = Zero;
            cnt_d   = Zero;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        div_d   = 1'b0;
      end
    endcase

    rise_d = div_d & ~div_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      div_q   <= 1'b0;
      rise_q  <= 1'b0;
      err_q   <= 1'b0;
      act_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rise_q  <= rise_d;
      err_q   <= err_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl. Stimulus computes expected outputs from a
// phase-age reference model and queues them; a monitor compares after each edge.
module tb_div_ratio_ctrl;

  localparam int HW = 5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [HW-1:0] cfg_ratio = '0;
  logic          cfg_ready, cfg_err, div_out, rise_pulse, busy;
  logic [HW-1:0] active_ratio;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct packed {
    logic          div;
    logic          rise;
    logic          err;
    logic          busy;
    logic          ready;
    logic [HW-1:0] active;
  } obs_t;

  obs_t exp_q[$];

  div_ratio_ctrl #(.HALF_W(HW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_valid   (cfg_valid),
    .cfg_ratio   (cfg_ratio),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .div_out     (div_out),
    .rise_pulse  (rise_pulse),
    .busy        (busy),
    .active_ratio(active_ratio)
  );

  always #5 clk = ~clk;

  // Reference model: a running divider is a sequence of phases, each m_ratio cycles
  // long; m_age counts cycles spent in the current phase.
  int   m_run, m_lvl, m_ratio, m_age, m_pv, m_pend;
  logic m_err;

  function automatic void model_reset();
    m_run = 0; m_lvl = 0; m_ratio = 0; m_age = 0; m_pv = 0; m_pend = 0; m_err = 1'b0;
  endfunction

  function automatic obs_t model_obs(input int old_lvl);
    obs_t o;
    o.div    = (m_lvl != 0);
    o.rise   = (m_lvl != 0) && (old_lvl == 0);
    o.err    = m_err;
    o.busy   = (m_run != 0);
    o.ready  = !(m_run != 0 && m_pv != 0);
    o.active = HW'(m_ratio);
    return o;
  endfunction

  function automatic obs_t model_edge(input logic v, input int r);
    int old_lvl = m_lvl;
    bit ready = !(m_run != 0 && m_pv != 0);
    bit acc = v && ready;
    m_err = 1'b0;
    if (m_run == 0) begin
      if (acc) begin
        if (r == 0) m_err = 1'b1;
        else begin
          m_run = 1; m_lvl = 1; m_ratio = r; m_age = 1;
        end
      end
    end else begin
      if (m_age == m_ratio) begin
        if (m_lvl == 1 && m_pv != 0) begin
          m_pv = 0;
          if (m_pend == 0) begin
            m_run = 0; m_lvl = 0; m_ratio = 0;
          end else begin
            m_ratio = m_pend; m_lvl = 0; m_age = 1;
          end
        end else begin
          m_lvl = 1 - m_lvl; m_age = 1;
        end
      end else begin
        m_age++;
      end
      if (acc) begin
        m_pv = 1; m_pend = r;
      end
    end
    return model_obs(old_lvl);
  endfunction

  task automatic step(input logic v, input int r);
    @(negedge clk);
    cfg_valid = v;
    cfg_ratio = HW'(r);
    exp_q.push_back(model_edge(v, r));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.div = div_out; o.rise = rise_pulse; o.err = cfg_err;
    o.busy = busy; o.ready = cfg_ready; o.active = active_ratio;
    return o;
  endfunction

  task automatic check_direct(input string name, input obs_t want);
    obs_t got = dut_obs();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got div=%b rise=%b err=%b busy=%b ready=%b active=%0d, want div=%b rise=%b err=%b busy=%b ready=%b active=%0d",
               name, got.div, got.rise, got.err, got.busy, got.ready, got.active,
               want.div, want.rise, want.err, want.busy, want.ready, want.active);
    end
  endtask

  // Monitor: after every active edge out of reset, compare against the queued value.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (resetn && exp_q.size() != 0) begin
      obs_t want;
      obs_t got;
      want = exp_q.pop_front();
      got  = dut_obs();
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle %0d: got div=%b rise=%b err=%b busy=%b ready=%b active=%0d, want div=%b rise=%b err=%b busy=%b ready=%b active=%0d",
                 cyc, got.div, got.rise, got.err, got.busy, got.ready, got.active,
                 want.div, want.rise, want.err, want.busy, want.ready, want.active);
      end
    end
  end

  initial begin
    obs_t rst_obs;
    rst_obs = '{div: 1'b0, rise: 1'b0, err: 1'b0, busy: 1'b0, ready: 1'b1, active: '0};
    model_reset();
    #22;
    check_direct("reset state", rst_obs);
    @(negedge clk);
    resetn = 1'b1;

    // Idle ratio 0 -> single error pulse.
    step(1'b1, 0);
    idle_steps(3);
    // Start at 3, stop at 0.
    step(1'b1, 3);
    idle_steps(9);
    step(1'b1, 0);
    idle_steps(8);
    // Ratio 2, change to 4 during a high phase.
    step(1'b1, 2);
    idle_steps(1);
    step(1'b1, 4);
    idle_steps(20);
    // Change to 1, then hammer valid during drain.
    step(1'b1, 1);
    for (int i = 0; i < 12; i++) step(1'(i % 2), 7);
    idle_steps(6);
    step(1'b1, 1);
    step(1'b1, 0);
    idle_steps(6);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic v;
      int   r;
      v = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                      : int'($urandom_range(0, 6));
      step(v, r);
    end

    // Reset while draining with div_out high.
    idle_steps(1);
    step(1'b1, 0);
    idle_steps(2);
    step(1'b1, 5);
    step(1'b1, 2);
    @(posedge clk);
    #2;
    cfg_valid = 1'b0;
    resetn = 1'b0;
    model_reset();
    #1;
    check_direct("async reset in drain", rst_obs);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step(1'b1, 5);
    idle_steps(25);

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
